// File: rtl/iiitb_bcd_pkg.sv
// Shared types and helpers for the digit-serial BCD adder.
// The single-digit add rule lives here so the stage and any model can reuse it.
package iiitb_bcd_pkg;

  localparam int DIGIT_W = 4;
  localparam int BCD_MAX = 9;
  localparam int BCD_ADJ = 6;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_t;

  // Returns {carry, digit}. A digit sum above 9 is pushed past 15 by adding 6,
  // which wraps it back into 0..9 and signals the decimal carry.
  function automatic logic [DIGIT_W:0] bcd_add_digit(
    input logic [DIGIT_W-1:0] a_d,
    input logic [DIGIT_W-1:0] b_d,
    input logic               c
  );
    logic [DIGIT_W:0] t;
    logic [DIGIT_W:0] adj;
    t   = {1'b0, a_d} + {1'b0, b_d} + {{DIGIT_W{1'b0}}, c};
    adj = t + (DIGIT_W+1)'(BCD_ADJ);
    if (t > (DIGIT_W+1)'(BCD_MAX)) begin
      bcd_add_digit = {1'b1, adj[DIGIT_W-1:0]};
    end else begin
      bcd_add_digit = {1'b0, t[DIGIT_W-1:0]};
    end
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Combinational one-digit BCD add stage; also flags non-BCD input digits.
module bcd_digit_add
  import iiitb_bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] a_d,
  input  logic [DIGIT_W-1:0] b_d,
  input  logic               c_in,
  output logic [DIGIT_W-1:0] digit,
  output logic               c_out,
  output logic               bad
);

  logic [DIGIT_W:0] res;

  always_comb begin
    res = bcd_add_digit(a_d, b_d, c_in);
  end

  assign digit = res[DIGIT_W-1:0];
  assign c_out = res[DIGIT_W];
  assign bad   = (a_d > DIGIT_W'(BCD_MAX)) || (b_d > DIGIT_W'(BCD_MAX));

endmodule

// File: rtl/iiitb_bcd_seq_adder.sv
// Digit-serial NDIG-digit BCD adder: accepts operands, adds one digit per
// cycle LSD first through a single bcd_digit_add stage, then holds the result.
module iiitb_bcd_seq_adder
  import iiitb_bcd_pkg::*;
#(
  parameter int NDIG = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DIGIT_W*NDIG-1:0] a,
  input  logic [DIGIT_W*NDIG-1:0] b,
  input  logic                    carry_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DIGIT_W*NDIG-1:0] sum,
  output logic                    carry_out,
  output logic                    err
);

  localparam int W     = DIGIT_W * NDIG;
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);

  state_t             state_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic               carry_reg;
  logic [W-1:0]       a_sh_reg;
  logic [W-1:0]       b_sh_reg;
  logic [W-1:0]       sum_reg;
  logic               carry_out_reg;
  logic               err_reg;

  logic [DIGIT_W-1:0] dig;
  logic               dig_c;
  logic               dig_bad;

  // Operands shift right each ADD cycle, so the current digit is always the low nibble.
  bcd_digit_add u_digit (
    .a_d   (a_sh_reg[DIGIT_W-1:0]),
    .b_d   (b_sh_reg[DIGIT_W-1:0]),
    .c_in  (carry_reg),
    .digit (dig),
    .c_out (dig_c),
    .bad   (dig_bad)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      carry_reg     <= 1'b0;
      a_sh_reg      <= '0;
      b_sh_reg      <= '0;
      sum_reg       <= '0;
      carry_out_reg <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_sh_reg  <= a;
            b_sh_reg  <= b;
            carry_reg <= carry_in;
            idx_reg   <= '0;
            err_reg   <= 1'b0;
            state_reg <= ADD;
          end
        end
        ADD: begin
          sum_reg[idx_reg*DIGIT_W +: DIGIT_W] <= dig;
          carry_reg <= dig_c;
          a_sh_reg  <= a_sh_reg >> DIGIT_W;
          b_sh_reg  <= b_sh_reg >> DIGIT_W;
          if (dig_bad) begin
            err_reg <= 1'b1;
          end
          if (idx_reg == LAST_IDX) begin
            carry_out_reg <= dig_c;
            state_reg     <= DONE;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        DONE: begin
          // Result registers are left untouched on exit so they stay readable in IDLE.
          if (out_ready) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign sum       = sum_reg;
  assign carry_out = carry_out_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_iiitb_bcd_seq_adder.sv
// Directed self-checking bench for the 4-digit sequential BCD adder.
module tb_iiitb_bcd_seq_adder;

  localparam int NDIG = 4;
  localparam int W    = 4 * NDIG;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         carry_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         err;

  int errors = 0;
  int checks = 0;

  iiitb_bcd_seq_adder #(.NDIG(NDIG)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present operands for one accept edge, then wait (bounded) for out_valid.
  // lat counts negedges after the accept edge until out_valid is seen; -1 on timeout.
  task automatic start_and_wait(input logic [W-1:0] av, input logic [W-1:0] bv,
                                input logic ci, input logic hold_valid, output int lat);
    a = av; b = bv; carry_in = ci; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold_valid) in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; carry_in = 1'b0;
    #12;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 16'h0 || carry_out !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset: in_ready=%b out_valid=%b sum=%h co=%b err=%b, want 1 0 0000 0 0",
               in_ready, out_valid, sum, carry_out, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    $display("reset: in_ready=%b out_valid=%b sum=%h", in_ready, out_valid, sum);
  endtask

  task automatic test_basic();
    int lat;
    start_and_wait(16'h1234, 16'h5678, 1'b0, 1'b0, lat);
    checks++;
    if (lat !== NDIG) begin
      errors++;
      $display("FAIL basic_latency: got %0d want %0d", lat, NDIG);
    end
    checks++;
    if (sum !== 16'h6912 || carry_out !== 1'b0 || err !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_sum: sum=%h co=%b err=%b in_ready=%b, want 6912 0 0 0", sum, carry_out, err, in_ready);
    end
    $display("1234+5678+0: sum=%h co=%b err=%b lat=%0d", sum, carry_out, err, lat);
    take_result();
  endtask

  task automatic test_carry();
    int lat;
    start_and_wait(16'h9999, 16'h0001, 1'b0, 1'b0, lat);
    checks++;
    if (lat < 0 || sum !== 16'h0000 || carry_out !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL carry_ripple: sum=%h co=%b err=%b lat=%0d, want 0000 1 0", sum, carry_out, err, lat);
    end
    $display("9999+0001+0: sum=%h co=%b err=%b", sum, carry_out, err);
    take_result();

    start_and_wait(16'h9999, 16'h9999, 1'b1, 1'b0, lat);
    checks++;
    if (lat < 0 || sum !== 16'h9999 || carry_out !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL carry_max: sum=%h co=%b err=%b lat=%0d, want 9999 1 0", sum, carry_out, err, lat);
    end
    $display("9999+9999+1: sum=%h co=%b err=%b", sum, carry_out, err);
    take_result();
  endtask

  task automatic test_invalid_digit();
    int lat;
    start_and_wait(16'h000A, 16'h0000, 1'b0, 1'b0, lat);
    checks++;
    if (lat < 0 || sum !== 16'h0010 || carry_out !== 1'b0 || err !== 1'b1) begin
      errors++;
      $display("FAIL invalid_low: sum=%h co=%b err=%b lat=%0d, want 0010 0 1", sum, carry_out, err, lat);
    end
    $display("000A+0000+0: sum=%h co=%b err=%b", sum, carry_out, err);
    take_result();

    // Bad digit in the top position: B+0 -> 1 with carry out of the word.
    start_and_wait(16'hB000, 16'h0000, 1'b0, 1'b0, lat);
    checks++;
    if (lat < 0 || sum !== 16'h1000 || carry_out !== 1'b1 || err !== 1'b1) begin
      errors++;
      $display("FAIL invalid_high: sum=%h co=%b err=%b lat=%0d, want 1000 1 1", sum, carry_out, err, lat);
    end
    $display("B000+0000+0: sum=%h co=%b err=%b", sum, carry_out, err);
    take_result();
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    start_and_wait(16'h1234, 16'h5678, 1'b0, 1'b0, lat);
    checks++;
    if (lat < 0 || sum !== 16'h6912 || err !== 1'b0) begin
      errors++;
      $display("FAIL bp_first: sum=%h err=%b lat=%0d, want 6912 0 (err cleared on accept)", sum, err, lat);
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0] ? 1'b0 : 1'b1;
      a = 16'h1111 * (i + 1);
      b = 16'h2222;
      @(negedge clk);
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== 16'h6912 || carry_out !== 1'b0 || err !== 1'b0) bad++;
    end
    in_valid = 1'b0;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL bp_hold: %0d unstable cycles, want 0 (sum=%h out_valid=%b in_ready=%b)", bad, sum, out_valid, in_ready);
    end
    take_result();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 16'h6912) begin
      errors++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b sum=%h, want 1 0 6912", in_ready, out_valid, sum);
    end
    $display("backpressure: held 5 cycles, sum=%h in_ready=%b", sum, in_ready);
  endtask

  task automatic test_back_to_back();
    int lat;
    start_and_wait(16'h0123, 16'h0456, 1'b0, 1'b1, lat);
    checks++;
    if (lat < 0 || sum !== 16'h0579 || carry_out !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first: sum=%h co=%b lat=%0d, want 0579 0", sum, carry_out, lat);
    end
    $display("0123+0456+0: sum=%h co=%b", sum, carry_out);
    // Second set is visible during DONE but must only be taken from IDLE.
    a = 16'h0999; b = 16'h0001; carry_in = 1'b0;
    take_result();
    checks++;
    if (in_ready !== 1'b1 || sum !== 16'h0579) begin
      errors++;
      $display("FAIL b2b_gap: in_ready=%b sum=%h, want 1 0579", in_ready, sum);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== NDIG || sum !== 16'h1000 || carry_out !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second: sum=%h co=%b lat=%0d, want 1000 0 %0d", sum, carry_out, lat, NDIG);
    end
    $display("0999+0001+0: sum=%h co=%b lat=%0d", sum, carry_out, lat);
    take_result();
  endtask

  task automatic test_reset_mid_add();
    int lat;
    a = 16'h4321; b = 16'h1111; carry_in = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== 16'h0 || carry_out !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: out_valid=%b in_ready=%b sum=%h co=%b err=%b, want 0 1 0000 0 0",
               out_valid, in_ready, sum, carry_out, err);
    end
    $display("reset mid-ADD: sum=%h in_ready=%b", sum, in_ready);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_and_wait(16'h0005, 16'h0005, 1'b0, 1'b0, lat);
    checks++;
    if (lat !== NDIG || sum !== 16'h0010 || carry_out !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL after_reset: sum=%h co=%b err=%b lat=%0d, want 0010 0 0 %0d", sum, carry_out, err, lat, NDIG);
    end
    $display("0005+0005+0: sum=%h co=%b", sum, carry_out);
    take_result();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_invalid_digit();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_add();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
